palette_loader: RTL

PALETTE_LOADER -- requirements
Module: palette_loader

---
 rtl/palette_if.sv | 24 ++
 rtl/palette_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/palette_if.sv
// Palette download / palette-RAM write bundle shared by the loader and its source.
interface palette_if;
    logic        pal_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        vblank;
    logic        ioctl_wait;
    logic        load_color;
    logic [23:0] load_color_data;
    logic [5:0]  load_color_index;
    logic        busy;
    logic        done;

    modport slave (
        input  pal_download, ioctl_wr, ioctl_addr, ioctl_dout, vblank,
        output ioctl_wait, load_color, load_color_data, load_color_index, busy, done
    );

    modport master (
        output pal_download, ioctl_wr, ioctl_addr, ioctl_dout, vblank,
        input  ioctl_wait, load_color, load_color_data, load_color_index, busy, done
    );
endinterface

// File: rtl/palette_loader.sv
// Assembles RGB triplets from a palette file download, buffers them in a small FIFO
// and commits them to palette RAM only while vblank is high.
module palette_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ENTRIES    = 64
) (
    input  logic      clk,
    input  logic      reset,
    palette_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned IdxW = $clog2(ENTRIES + 1);
    localparam logic [CntW-1:0] FullLvl  = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] WaitLvl  = CntW'(FIFO_DEPTH - 1);
    localparam logic [IdxW-1:0] EntryLim = IdxW'(ENTRIES);

    typedef enum logic [1:0] {StIdle, StRecv, StDrain} state_e;

    state_e            state_q, state_d;
    logic              dl_q;
    logic [1:0]        phase_q, phase_d;
    logic [IdxW-1:0]   index_q, index_d;
    logic [7:0]        r_q, r_d, g_q, g_d;
    logic [29:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              wait_q, lc_q;
    logic [23:0]       lc_data_q;
    logic [5:0]        lc_index_q;

    logic              dl_rise, dl_fall, wr_en, push, push_ok, pop, done_c;
    logic [29:0]       push_data;
    logic [1:0]        eff_phase;
    logic [IdxW-1:0]   eff_index;

    assign dl_rise = bus.pal_download & ~dl_q;
    assign dl_fall = ~bus.pal_download & dl_q;
    assign pop     = bus.vblank & (count_q != '0);
    // A push into a full FIFO only happens if the source ignores ioctl_wait; drop it.
    assign push_ok = push & (count_q != FullLvl);
    assign count_d = count_q + CntW'(push_ok) - CntW'(pop);

    // Byte assembly: R/G/B phase tracking, realignment on address 0, entry push.
    always_comb begin
        phase_d   = phase_q;
        index_d   = index_q;
        r_d       = r_q;
        g_d       = g_q;
        push      = 1'b0;
        push_data = '0;
        eff_phase = phase_q;
        eff_index = index_q;
        wr_en     = bus.ioctl_wr && (state_q == StRecv) && !dl_fall;
        if (bus.ioctl_addr == '0) begin
            eff_phase = '0;
            eff_index = '0;
        end
        if (dl_rise) begin
            phase_d = '0;
            index_d = '0;
        end else if (wr_en) begin
            index_d = eff_index;
            case (eff_phase)
                2'd0: begin
                    r_d     = bus.ioctl_dout;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    g_d     = bus.ioctl_dout;
                    phase_d = 2'd2;
                end
                default: begin
                    phase_d = 2'd0;
                    // Entries past the table size are swallowed without a push.
                    if (eff_index < EntryLim) begin
                        push      = 1'b1;
                        push_data = {6'(eff_index), r_q, g_q, bus.ioctl_dout};
                        index_d   = eff_index + IdxW'(1);
                    end
                end
            endcase
        end
    end

    // Download state machine; done fires in the cycle DRAIN hands back to IDLE.
    always_comb begin
        state_d = state_q;
        done_c  = 1'b0;
        unique case (state_q)
            StIdle:  if (dl_rise) state_d = StRecv;
            StRecv:  if (dl_fall) state_d = StDrain;
            StDrain: begin
                if (dl_rise) begin
                    state_d = StRecv;
                end else if ((count_q == '0) && !lc_q) begin
                    state_d = StIdle;
                    done_c  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, FIFO bookkeeping and registered palette-RAM outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            dl_q       <= 1'b0;
            phase_q    <= '0;
            index_q    <= '0;
            r_q        <= '0;
            g_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= 1'b0;
            lc_q       <= 1'b0;
            lc_data_q  <= '0;
            lc_index_q <= '0;
        end else begin
            state_q <= state_d;
            dl_q    <= bus.pal_download;
            phase_q <= phase_d;
            index_q <= index_d;
            r_q     <= r_d;
            g_q     <= g_d;
            count_q <= count_d;
            // One slot of headroom so a triplet already in flight still fits.
            wait_q  <= (count_d >= WaitLvl);
            lc_q    <= pop;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) begin
                rd_ptr_q                <= rd_ptr_q + PtrW'(1);
                {lc_index_q, lc_data_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    // FIFO storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign bus.ioctl_wait       = wait_q;
    assign bus.load_color       = lc_q;
    assign bus.load_color_data  = lc_data_q;
    assign bus.load_color_index = lc_index_q;
    assign bus.busy             = (state_q != StIdle) & ~reset;
    assign bus.done             = done_c & ~reset;
endmodule
